// File: rtl/alarm_sequencer.sv
// Alarm tune sequencer: starts the player on an alarm match, handles snooze/stop and ring
// timeout, and rotates the song choice on each re-ring after a snooze.
module alarm_sequencer #(
    parameter int unsigned RING_TIMEOUT_SEC = 60,
    parameter int unsigned SNOOZE_SEC       = 300,
    parameter int unsigned MAX_SNOOZES      = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tick_1hz,
    input  logic                               alarm_match,
    input  logic                               alarm_enable,
    input  logic                               snooze_btn,
    input  logic                               stop_btn,
    input  logic [1:0]                         cfg_sel,
    output logic                               alarm,
    output logic [1:0]                         sel,
    output logic                               song_restart,
    output logic                               snoozing,
    output logic [$clog2(MAX_SNOOZES+1)-1:0]   snooze_cnt
);

    localparam int unsigned TimerMax = (RING_TIMEOUT_SEC > SNOOZE_SEC) ? RING_TIMEOUT_SEC
                                                                       : SNOOZE_SEC;
    localparam int unsigned TimerW   = $clog2(TimerMax + 1);
    localparam int unsigned CntW     = $clog2(MAX_SNOOZES + 1);

    typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d, timer_inc;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          sel_q, sel_d, norm_sel, sel_rot;
    logic [CntW+1:0]     sel_sum;
    logic                restart_q, restart_d;
    logic                alarm_q, snoozing_q;
    logic                armed_q, armed_d;
    logic                snooze_btn_q, stop_btn_q;
    logic                snooze_press, stop_press, quit;

    assign snooze_press = snooze_btn & ~snooze_btn_q;
    assign stop_press   = stop_btn & ~stop_btn_q;
    assign quit         = stop_press | ~alarm_enable;
    assign norm_sel     = (cfg_sel == 2'd3) ? 2'd0 : cfg_sel;
    assign timer_inc    = timer_q + TimerW'(1);
    // Each re-ring after a snooze moves one song further along from the user's choice.
    assign sel_sum      = (CntW+2)'(norm_sel) + (CntW+2)'(cnt_q);
    assign sel_rot      = 2'(sel_sum % (CntW+2)'(3));

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        restart_d = 1'b0;
        // Re-arm only once the match condition has gone away.
        armed_d   = alarm_match ? armed_q : 1'b1;
        unique case (state_q)
            StIdle: begin
                if (alarm_enable && alarm_match && armed_q) begin
                    state_d   = StRing;
                    timer_d   = '0;
                    cnt_d     = '0;
                    sel_d     = norm_sel;
                    restart_d = 1'b1;
                    armed_d   = 1'b0;
                end
            end
            StRing: begin
                if (quit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (snooze_press && (cnt_q < CntW'(MAX_SNOOZES))) begin
                    state_d = StSnooze;
                    cnt_d   = cnt_q + CntW'(1);
                    timer_d = '0;
                end else if (tick_1hz) begin
                    timer_d = timer_inc;
                    if (timer_inc == TimerW'(RING_TIMEOUT_SEC)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        timer_d = '0;
                    end
                end
            end
            StSnooze: begin
                if (quit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (tick_1hz) begin
                    timer_d = timer_inc;
                    if (timer_inc == TimerW'(SNOOZE_SEC)) begin
                        state_d   = StRing;
                        timer_d   = '0;
                        sel_d     = sel_rot;
                        restart_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            cnt_q        <= '0;
            sel_q        <= 2'd0;
            restart_q    <= 1'b0;
            alarm_q      <= 1'b0;
            snoozing_q   <= 1'b0;
            armed_q      <= 1'b1;
            snooze_btn_q <= 1'b0;
            stop_btn_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            restart_q    <= restart_d;
            alarm_q      <= (state_d == StRing);
            snoozing_q   <= (state_d == StSnooze);
            armed_q      <= armed_d;
            snooze_btn_q <= snooze_btn;
            stop_btn_q   <= stop_btn;
        end
    end

    assign alarm        = alarm_q;
    assign sel          = sel_q;
    assign song_restart = restart_q;
    assign snoozing     = snoozing_q;
    assign snooze_cnt   = cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: per-cycle comparison against a countdown-based model,
// plus hand-computed literal checks at the key points of each scenario.
module tb_alarm_sequencer;

    localparam int RT = 4;
    localparam int SS = 3;
    localparam int MX = 2;
    localparam int TICK_PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       alarm_match = 1'b0;
    logic       alarm_enable = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic [1:0] cfg_sel = 2'd0;
    logic       alarm, song_restart, snoozing;
    logic [1:0] sel;
    logic [1:0] snooze_cnt;

    int n_checks = 0;
    int n_pass = 0;

    alarm_sequencer #(
        .RING_TIMEOUT_SEC(RT),
        .SNOOZE_SEC      (SS),
        .MAX_SNOOZES     (MX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .alarm_match (alarm_match),
        .alarm_enable(alarm_enable),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .cfg_sel     (cfg_sel),
        .alarm       (alarm),
        .sel         (sel),
        .song_restart(song_restart),
        .snoozing    (snoozing),
        .snooze_cnt  (snooze_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tick_1hz = (cnt == TICK_PERIOD - 1);
            cnt = (cnt + 1) % TICK_PERIOD;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: mode 0 silent, 1 ringing, 2 snoozed; m_left counts remaining seconds.
    int m_mode = 0;
    int m_left = 0;
    int m_used = 0;
    int e_sel = 0;
    bit e_restart = 0;
    bit m_armed = 1;
    bit m_psnz = 0;
    bit m_pstop = 0;

    function automatic int song(input int c);
        return (c == 3) ? 0 : c;
    endfunction

    initial begin
        bit sp, tp;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_mode = 0; m_left = 0; m_used = 0; e_sel = 0; e_restart = 0;
                m_armed = 1; m_psnz = 0; m_pstop = 0;
                continue;
            end
            sp = snooze_btn && !m_psnz;
            tp = stop_btn && !m_pstop;
            m_psnz = snooze_btn;
            m_pstop = stop_btn;
            e_restart = 0;
            if (m_mode == 0) begin
                if (alarm_enable && alarm_match && m_armed) begin
                    m_mode = 1; m_left = RT; m_used = 0;
                    e_sel = song(int'(cfg_sel)); e_restart = 1; m_armed = 0;
                end
            end else if (tp || !alarm_enable) begin
                m_mode = 0; m_used = 0;
            end else if (m_mode == 1) begin
                if (sp && m_used < MX) begin
                    m_mode = 2; m_used++; m_left = SS;
                end else if (tick_1hz) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 0; m_used = 0; end
                end
            end else if (tick_1hz) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 1; m_left = RT;
                    e_sel = (song(int'(cfg_sel)) + m_used) % 3; e_restart = 1;
                end
            end
            if (!alarm_match) m_armed = 1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("m_alarm", int'(alarm), int'(m_mode == 1));
            chk("m_snoozing", int'(snoozing), int'(m_mode == 2));
            chk("m_sel", int'(sel), e_sel);
            chk("m_restart", int'(song_restart), int'(e_restart));
            chk("m_snooze_cnt", int'(snooze_cnt), m_used);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_restart(input string name);
        bit found = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (song_restart) begin
                found = 1;
                break;
            end
        end
        chk(name, int'(found), 1);
    endtask

    initial begin
        bit got_tick;
        cyc(3);
        chk("rst_alarm", int'(alarm), 0);
        chk("rst_cnt", int'(snooze_cnt), 0);
        rst = 1'b1; alarm_enable = 1'b1; cfg_sel = 2'd1;
        cyc(2);

        // 1: ring, timeout, no re-ring while match stays high
        alarm_match = 1'b1;
        cyc(1);
        chk("t1_alarm", int'(alarm), 1);
        chk("t1_sel", int'(sel), 1);
        chk("t1_restart", int'(song_restart), 1);
        cyc(1);
        chk("t1_restart_once", int'(song_restart), 0);
        cyc(46);
        chk("t1_timeout", int'(alarm), 0);
        cyc(2);
        chk("t1_no_rering", int'(alarm), 0);
        alarm_match = 1'b0;

        // 2: snooze and song rotation
        cyc(2);
        cfg_sel = 2'd2; alarm_match = 1'b1;
        cyc(1);
        alarm_match = 1'b0;
        chk("t2_sel", int'(sel), 2);
        snooze_btn = 1'b1;
        cyc(1);
        snooze_btn = 1'b0;
        chk("t2_alarm_off", int'(alarm), 0);
        chk("t2_snoozing", int'(snoozing), 1);
        chk("t2_cnt", int'(snooze_cnt), 1);
        wait_restart("t2_restart_seen");
        chk("t2_alarm_on", int'(alarm), 1);
        chk("t2_sel_rot", int'(sel), 0);

        // 3: snooze limit, then stop
        cyc(1);
        snooze_btn = 1'b1;
        cyc(1);
        snooze_btn = 1'b0;
        chk("t3_cnt2", int'(snooze_cnt), 2);
        wait_restart("t3_restart_seen");
        chk("t3_sel_rot", int'(sel), 1);
        cyc(1);
        snooze_btn = 1'b1;
        cyc(1);
        snooze_btn = 1'b0;
        chk("t3_ignored_alarm", int'(alarm), 1);
        chk("t3_ignored_cnt", int'(snooze_cnt), 2);
        cyc(1);
        stop_btn = 1'b1;
        cyc(1);
        stop_btn = 1'b0;
        chk("t3_stop_alarm", int'(alarm), 0);
        chk("t3_stop_cnt", int'(snooze_cnt), 0);

        // 4: stop beats snooze; snooze beats tick
        cyc(2);
        alarm_match = 1'b1;
        cyc(1);
        alarm_match = 1'b0;
        chk("t4_ring", int'(alarm), 1);
        stop_btn = 1'b1; snooze_btn = 1'b1;
        cyc(1);
        stop_btn = 1'b0; snooze_btn = 1'b0;
        chk("t4_stop_wins", int'(alarm), 0);
        chk("t4_not_snoozing", int'(snoozing), 0);
        cyc(2);
        alarm_match = 1'b1;
        cyc(1);
        alarm_match = 1'b0;
        chk("t4_ring2", int'(alarm), 1);
        got_tick = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (tick_1hz) begin
                got_tick = 1;
                break;
            end
        end
        chk("t4_tick_found", int'(got_tick), 1);
        snooze_btn = 1'b1;
        cyc(1);
        snooze_btn = 1'b0;
        chk("t4_snooze", int'(snoozing), 1);
        cyc(24);
        chk("t4_timer_cleared", int'(snoozing), 1);
        cyc(6);
        chk("t4_reringing", int'(alarm), 1);

        // 5: disable during snooze; cfg_sel 3 maps to song 0
        snooze_btn = 1'b1;
        cyc(1);
        snooze_btn = 1'b0;
        chk("t5_snooze", int'(snoozing), 1);
        alarm_enable = 1'b0;
        cyc(1);
        chk("t5_idle_alarm", int'(alarm), 0);
        chk("t5_idle_snoozing", int'(snoozing), 0);
        chk("t5_idle_cnt", int'(snooze_cnt), 0);
        cyc(40);
        chk("t5_stays_off", int'(alarm), 0);
        alarm_enable = 1'b1; cfg_sel = 2'd3; alarm_match = 1'b1;
        cyc(1);
        alarm_match = 1'b0;
        chk("t5_ring", int'(alarm), 1);
        chk("t5_sel3", int'(sel), 0);

        // 6: reset mid-ring with snooze held through release
        cyc(2);
        snooze_btn = 1'b1; rst = 1'b0;
        #1;
        chk("t6_alarm", int'(alarm), 0);
        chk("t6_sel", int'(sel), 0);
        chk("t6_restart", int'(song_restart), 0);
        cyc(3);
        rst = 1'b1;
        cyc(5);
        chk("t6_no_snooze", int'(snoozing), 0);
        chk("t6_no_alarm", int'(alarm), 0);
        snooze_btn = 1'b0;
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
